// File: rtl/rvfi_order_serializer.sv
// rtl/rvfi_order_serializer.sv - reorders RVFI retirements into one ascending-order stream (optional: RVFI_ORDER_SERIALIZER_BYPASS_EN)
module rvfi_order_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NRET-1:0]      in_valid,
    input  logic [64*NRET-1:0]   in_order,
    input  logic [32*NRET-1:0]   in_insn,
    input  logic [5*NRET-1:0]    in_rs1_addr,
    input  logic [5*NRET-1:0]    in_rs2_addr,
    input  logic [5*NRET-1:0]    in_rd_addr,
    input  logic [XLEN*NRET-1:0] in_rd_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_order,
    output logic [31:0]          out_insn,
    output logic [4:0]           out_rs1_addr,
    output logic [4:0]           out_rs2_addr,
    output logic [4:0]           out_rd_addr,
    output logic [XLEN-1:0]      out_rd_wdata,
    output logic [AW:0]          count,
    output logic                 err_stale,
    output logic                 err_dup,
    output logic                 err_overflow
);
    localparam int PW = 64 + 32 + 15 + XLEN;

    logic [PW-1:0]    slot_data_q [DEPTH];
    logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [63:0]      expected_q, expected_d;
    logic [PW-1:0]    out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [AW:0]      count_q, count_d;
    logic             stale_q, stale_d, dup_q, dup_d, ovf_q, ovf_d;

    logic [63:0]      ch_order [NRET];
    logic [PW-1:0]    ch_rec   [NRET];
    logic [DEPTH-1:0] wr_en, taken;
    logic [PW-1:0]    wr_data  [DEPTH];
    logic [AW-1:0]    head, wslot;
    logic [63:0]      delta;
    logic             out_free, pop, byp;
    logic [NRET-1:0]  byp_sel;
    logic [PW-1:0]    byp_data;

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            ch_order[i] = in_order[64*i +: 64];
            ch_rec[i]   = {in_order[64*i +: 64], in_insn[32*i +: 32], in_rs1_addr[5*i +: 5],
                           in_rs2_addr[5*i +: 5], in_rd_addr[5*i +: 5], in_rd_wdata[XLEN*i +: XLEN]};
        end
    end

    always_comb begin
        head     = expected_q[AW-1:0];
        out_free = !out_valid_q || out_ready;
        pop      = out_free && slot_vld_q[head];
        byp      = 1'b0;
        byp_sel  = '0;
        byp_data = '0;
`ifdef RVFI_ORDER_SERIALIZER_BYPASS_EN
        if (out_free && !slot_vld_q[head]) begin
            for (int i = 0; i < NRET; i++) begin
                if (!byp && in_valid[i] && ch_order[i] == expected_q) begin
                    byp        = 1'b1;
                    byp_sel[i] = 1'b1;
                    byp_data   = ch_rec[i];
                end
            end
        end
`endif
        // A bypassed record claims the head slot so a same-cycle twin is flagged as duplicate.
        taken   = slot_vld_q;
        if (byp) taken[head] = 1'b1;
        wr_en   = '0;
        delta   = '0;
        wslot   = '0;
        stale_d = stale_q;
        dup_d   = dup_q;
        ovf_d   = ovf_q;
        for (int d = 0; d < DEPTH; d++) wr_data[d] = '0;
        for (int i = 0; i < NRET; i++) begin
            delta = ch_order[i] - expected_q;
            wslot = ch_order[i][AW-1:0];
            if (in_valid[i] && !byp_sel[i]) begin
                if (delta[63]) begin
                    stale_d = 1'b1;
                end else if (delta < 64'(DEPTH)) begin
                    if (taken[wslot]) begin
                        dup_d = 1'b1;
                    end else begin
                        taken[wslot]   = 1'b1;
                        wr_en[wslot]   = 1'b1;
                        wr_data[wslot] = ch_rec[i];
                    end
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        slot_vld_d = slot_vld_q;
        if (pop) slot_vld_d[head] = 1'b0;
        slot_vld_d = slot_vld_d | wr_en;
        count_d = '0;
        for (int d = 0; d < DEPTH; d++) count_d = count_d + {{AW{1'b0}}, slot_vld_d[d]};

        out_d       = out_q;
        out_valid_d = out_valid_q;
        expected_d  = expected_q;
        if (pop) begin
            out_d       = slot_data_q[head];
            out_valid_d = 1'b1;
            expected_d  = expected_q + 64'd1;
        end else if (byp) begin
            out_d       = byp_data;
            out_valid_d = 1'b1;
            expected_d  = expected_q + 64'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_vld_q  <= '0;
            expected_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            stale_q     <= 1'b0;
            dup_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            expected_q  <= expected_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            stale_q     <= stale_d;
            dup_q       <= dup_d;
            ovf_q       <= ovf_d;
        end
    end

    // Payload needs no reset: it is only observed through the reset-cleared valid bits.
    always_ff @(posedge clock) begin
        for (int d = 0; d < DEPTH; d++) begin
            if (wr_en[d]) slot_data_q[d] <= wr_data[d];
        end
    end

    assign {out_order, out_insn, out_rs1_addr, out_rs2_addr, out_rd_addr, out_rd_wdata} = out_q;
    assign out_valid    = out_valid_q;
    assign count        = count_q;
    assign err_stale    = stale_q;
    assign err_dup      = dup_q;
    assign err_overflow = ovf_q;
endmodule

// File: tb/tb_rvfi_order_serializer.sv
// tb/tb_rvfi_order_serializer.sv - table-driven bench for rvfi_order_serializer
module tb_rvfi_order_serializer;
    localparam int NRET = 2, XLEN = 32, DEPTH = 8, AW = 3;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic [NRET-1:0]      in_valid = '0;
    logic [64*NRET-1:0]   in_order = '0;
    logic [32*NRET-1:0]   in_insn = '0;
    logic [5*NRET-1:0]    in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic [XLEN*NRET-1:0] in_rd_wdata = '0;
    logic                 out_valid, out_ready = 1'b1;
    logic [63:0]          out_order;
    logic [31:0]          out_insn;
    logic [4:0]           out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [XLEN-1:0]      out_rd_wdata;
    logic [AW:0]          count;
    logic                 err_stale, err_dup, err_overflow;

    int total = 0, bad = 0;

    rvfi_order_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_order(in_order),
        .in_insn(in_insn), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_order(out_order), .out_insn(out_insn),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_rd_wdata(out_rd_wdata), .count(count), .err_stale(err_stale), .err_dup(err_dup),
        .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [63:0] o0, o1;
        logic        rdy;
        logic        ev;
        logic [63:0] eo;
        int          ec;
        logic [2:0]  ee;   // {stale, dup, overflow}
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] ins_of(input logic [63:0] o);
        return 32'hA000_0000 ^ o[31:0];
    endfunction
    function automatic logic [31:0] wd_of(input logic [63:0] o);
        return o[31:0] * 32'd7;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic rdy);
        in_valid    = v;
        in_order    = {o1, o0};
        in_insn     = {ins_of(o1), ins_of(o0)};
        in_rs1_addr = {o1[4:0] + 5'd1, o0[4:0] + 5'd1};
        in_rs2_addr = {o1[4:0] + 5'd2, o0[4:0] + 5'd2};
        in_rd_addr  = {o1[4:0] + 5'd3, o0[4:0] + 5'd3};
        in_rd_wdata = {wd_of(o1), wd_of(o0)};
        out_ready   = rdy;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        resetn   = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_err", 64'({err_stale, err_dup, err_overflow}), 64'd0);
        resetn = 1'b1;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [63:0] eo,
                               input int ec, input logic [2:0] ee);
        check({tag, "_valid"}, 64'(out_valid), 64'(ev));
        if (ev) begin
            check({tag, "_order"}, out_order, eo);
            check({tag, "_insn"}, 64'(out_insn), 64'(ins_of(eo)));
            check({tag, "_rd"}, 64'(out_rd_addr), 64'(eo[4:0] + 5'd3));
            check({tag, "_wdata"}, 64'(out_rd_wdata), 64'(wd_of(eo)));
        end
        check({tag, "_count"}, 64'(count), 64'(ec));
        check({tag, "_err"}, 64'({err_stale, err_dup, err_overflow}), 64'(ee));
    endtask

    task automatic add(input logic rst, input logic [1:0] v, input int o0, input int o1,
                       input logic rdy, input logic ev, input int eo, input int ec,
                       input logic [2:0] ee);
        vec_t r;
        r.rst = rst; r.v = v; r.o0 = 64'(o0); r.o1 = 64'(o1); r.rdy = rdy;
        r.ev = ev; r.eo = 64'(eo); r.ec = ec; r.ee = ee;
        tbl.push_back(r);
    endtask

    initial begin
        // in-order stream, 2-edge latency
        add(1, 2'b01, 0, 0, 1, 0, 0, 1, 3'b000);
        add(0, 2'b01, 1, 0, 1, 1, 0, 1, 3'b000);
        add(0, 2'b01, 2, 0, 1, 1, 1, 1, 3'b000);
        add(0, 2'b01, 3, 0, 1, 1, 2, 1, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 3, 0, 3'b000);
        add(0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000);
        // swapped channels
        add(1, 2'b11, 1, 0, 1, 0, 0, 2, 3'b000);
        add(0, 2'b11, 3, 2, 1, 1, 0, 3, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 1, 2, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 2, 1, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 3, 0, 3'b000);
        add(0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000);
        // backpressure and overflow window edge
        add(1, 2'b11, 0, 1, 0, 0, 0, 2, 3'b000);
        add(0, 2'b11, 2, 3, 0, 1, 0, 3, 3'b000);
        add(0, 2'b11, 4, 5, 0, 1, 0, 5, 3'b000);
        add(0, 2'b11, 6, 7, 0, 1, 0, 7, 3'b000);
        add(0, 2'b01, 8, 0, 0, 1, 0, 8, 3'b000);
        add(0, 2'b01, 9, 0, 0, 1, 0, 8, 3'b001);
        add(0, 2'b00, 0, 0, 1, 1, 1, 7, 3'b001);
        // stale and duplicate
        add(1, 2'b11, 0, 1, 1, 0, 0, 2, 3'b000);
        add(0, 2'b11, 2, 3, 1, 1, 0, 3, 3'b000);
        add(0, 2'b01, 4, 0, 1, 1, 1, 3, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 2, 2, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 3, 1, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 4, 0, 3'b000);
        add(0, 2'b01, 2, 0, 1, 0, 0, 0, 3'b100);
        add(0, 2'b11, 6, 6, 1, 0, 0, 1, 3'b110);
        add(0, 2'b01, 6, 0, 1, 0, 0, 1, 3'b110);
        // gap stalls until the missing order arrives
        add(1, 2'b11, 1, 2, 1, 0, 0, 2, 3'b000);
        add(0, 2'b01, 3, 0, 1, 0, 0, 3, 3'b000);
        add(0, 2'b00, 0, 0, 1, 0, 0, 3, 3'b000);
        add(0, 2'b01, 0, 0, 1, 0, 0, 4, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 0, 3, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 1, 2, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 2, 1, 3'b000);
        add(0, 2'b00, 0, 0, 1, 1, 3, 0, 3'b000);

        #7;
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) do_reset();
            drive(tbl[k].v, tbl[k].o0, tbl[k].o1, tbl[k].rdy);
            step();
            check_state($sformatf("row%0d", k), tbl[k].ev, tbl[k].eo, tbl[k].ec, tbl[k].ee);
        end

        // reset asserted between edges with records buffered and an error flagged
        do_reset();
        drive(2'b11, 64'd0, 64'd1, 1'b0);
        step();
        drive(2'b11, 64'd2, 64'd3, 1'b0);
        step();
        drive(2'b01, 64'd0, 64'd0, 1'b0);
        step();
        check_state("mid_pre", 1'b1, 64'd0, 3, 3'b100);
        do_reset();
        drive(2'b01, 64'd0, 64'd0, 1'b1);
        step();
        check_state("mid_post0", 1'b0, 64'd0, 1, 3'b000);
        drive(2'b01, 64'd1, 64'd0, 1'b1);
        step();
        check_state("mid_post1", 1'b1, 64'd0, 1, 3'b000);
        drive(2'b00, 64'd0, 64'd0, 1'b1);
        step();
        check_state("mid_post2", 1'b1, 64'd1, 0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
